writeback_unit: RTL and testbench



---
 rtl/writeback_unit_pkg.sv | 19 +
 rtl/writeback_unit_load_align.sv | 43 ++++
 rtl/writeback_unit.sv | 99 +++++++++
 tb/tb_writeback_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared constants for the writeback stage:
// load funct3 encodings and the zero register.
package writeback_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic is_zero_reg(
    input logic [4:0] r
  );
    return r == REG_ZERO;
  endfunction

endpackage

// File: rtl/writeback_unit_load_align.sv
// Load data extract/extend for LB/LH/LW/LBU/LHU.
// Purely combinational; halfword offset[0] ignored.
module load_align
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] aligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // pick the addressed byte and halfword
  always_comb begin
    byte_v = rdata[7:0];
    unique case (offset)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
    endcase
    half_v = offset[1] ? rdata[31:16]
                       : rdata[15:0];
  end

  // extend according to the load type
  always_comb begin
    aligned = rdata;
    case (funct3)
      F3_LB:  aligned = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: aligned = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:  aligned = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU: aligned = {{(XLEN-16){1'b0}}, half_v};
      F3_LW:  aligned = rdata;
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: ALU/load merge, register
// file write port and pending-load scoreboard.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNTW  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_hazard,
  output logic            rs2_hazard,
  output logic            w_enabled,
  output logic [4:0]      w_addr,
  output logic [XLEN-1:0] w_data,
  output logic [CNTW-1:0] wb_count
);

  logic [XLEN-1:0]  ld_aligned;
  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_next;
  logic             alu_wr;
  logic             ld_acc;
  logic             ld_wr;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (ld_funct3),
    .offset  (ld_offset),
    .rdata   (ld_rdata),
    .aligned (ld_aligned)
  );

  // ALU to a real register has strict priority
  always_comb begin
    alu_wr   = alu_valid && !is_zero_reg(alu_rd);
    ld_ready = !alu_wr;
    ld_acc   = ld_valid && ld_ready;
    ld_wr    = ld_acc && !is_zero_reg(ld_rd);
  end

  // scoreboard update: clear on accept, set wins
  always_comb begin
    sb_next = sb;
    if (ld_acc)
      sb_next[ld_rd] = 1'b0;
    if (issue_valid && !is_zero_reg(issue_rd))
      sb_next[issue_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // hazards reflect registered state only
  always_comb begin
    rs1_hazard = sb[rs1_addr]
              && !is_zero_reg(rs1_addr);
    rs2_hazard = sb[rs2_addr]
              && !is_zero_reg(rs2_addr);
  end

  // write port, scoreboard and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      w_enabled <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      wb_count  <= '0;
      sb        <= '0;
    end else begin
      sb <= sb_next;
      if (alu_wr) begin
        w_enabled <= 1'b1;
        w_addr    <= alu_rd;
        w_data    <= alu_data;
        wb_count  <= wb_count + 1'b1;
      end else if (ld_wr) begin
        w_enabled <= 1'b1;
        w_addr    <= ld_rd;
        w_data    <= ld_aligned;
        wb_count  <= wb_count + 1'b1;
      end else begin
        w_enabled <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit.
// Hand-computed expectations, one checking task.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [31:0] ld_rdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_hazard;
  logic        rs2_hazard;
  logic        w_enabled;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] wb_count;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_unit dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_funct3   (ld_funct3),
    .ld_offset   (ld_offset),
    .ld_rdata    (ld_rdata),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_hazard  (rs1_hazard),
    .rs2_hazard  (rs2_hazard),
    .w_enabled   (w_enabled),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .wb_count    (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_chk(
    input string       tag,
    input logic [4:0]  addr,
    input logic [31:0] data
  );
    chk({tag, "_wen"}, 32'(w_enabled), 1);
    chk({tag, "_addr"}, 32'(w_addr), 32'(addr));
    chk({tag, "_data"}, w_data, data);
  endtask

  task automatic align(
    input string       tag,
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] exp
  );
    ld_valid  = 1'b1;
    ld_rd     = 5'd10;
    ld_funct3 = f3;
    ld_offset = off;
    ld_rdata  = 32'h80FF7F01;
    step();
    ld_valid = 1'b0;
    wr_chk(tag, 5'd10, exp);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0;
    alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0;
    ld_funct3 = 3'b010; ld_offset = '0;
    ld_rdata = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_wen", 32'(w_enabled), 0);
    chk("rst_addr", 32'(w_addr), 0);
    chk("rst_data", w_data, 0);
    chk("rst_cnt", wb_count, 0);
    chk("rst_rdy", 32'(ld_ready), 1);
    chk("rst_hz1", 32'(rs1_hazard), 0);
    chk("rst_hz2", 32'(rs2_hazard), 0);

    // ALU beats load
    alu_valid = 1'b1; alu_rd = 5'd5;
    alu_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd6;
    ld_funct3 = 3'b010;
    ld_rdata = 32'hCAFE0000;
    #1;
    chk("arb_rdy0", 32'(ld_ready), 0);
    step();
    wr_chk("arb_alu", 5'd5, 32'h11);
    chk("arb_cnt1", wb_count, 1);
    alu_valid = 1'b0;
    #1;
    chk("arb_rdy1", 32'(ld_ready), 1);
    step();
    ld_valid = 1'b0;
    wr_chk("arb_ld", 5'd6, 32'hCAFE0000);
    chk("arb_cnt2", wb_count, 2);
    step();
    chk("idle_wen", 32'(w_enabled), 0);
    chk("idle_addr", 32'(w_addr), 6);
    chk("idle_data", w_data, 32'hCAFE0000);

    // alignment, word 0x80FF7F01
    align("lb3", 3'b000, 2'd3, 32'hFFFFFF80);
    align("lbu1", 3'b100, 2'd1, 32'h0000007F);
    align("lh2", 3'b001, 2'd2, 32'hFFFF80FF);
    align("lhu0", 3'b101, 2'd0, 32'h00007F01);
    align("lw", 3'b010, 2'd0, 32'h80FF7F01);
    align("lh3", 3'b001, 2'd3, 32'hFFFF80FF);
    align("f3_111", 3'b111, 2'd1, 32'h80FF7F01);
    align("lb0", 3'b000, 2'd0, 32'h00000001);
    chk("algn_cnt", wb_count, 10);

    // scoreboard set / clear
    issue_valid = 1'b1; issue_rd = 5'd7;
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    chk("sb_same", 32'(rs1_hazard), 0);
    step();
    issue_valid = 1'b0;
    #1;
    chk("sb_set1", 32'(rs1_hazard), 1);
    chk("sb_set2", 32'(rs2_hazard), 1);
    ld_valid = 1'b1; ld_rd = 5'd7;
    ld_funct3 = 3'b010;
    ld_rdata = 32'h12345678;
    #1;
    chk("sb_pre", 32'(rs1_hazard), 1);
    step();
    ld_valid = 1'b0;
    chk("sb_clr", 32'(rs1_hazard), 0);
    wr_chk("sb_wr", 5'd7, 32'h12345678);

    // set wins over clear
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    ld_valid = 1'b1; ld_rd = 5'd7;
    ld_rdata = 32'h0000ABCD;
    step();
    issue_valid = 1'b0; ld_valid = 1'b0;
    chk("sb_win", 32'(rs1_hazard), 1);
    wr_chk("sb_win", 5'd7, 32'h0000ABCD);
    ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    chk("sb_win_clr", 32'(rs1_hazard), 0);

    // blocked load does not clear
    issue_valid = 1'b1; issue_rd = 5'd8;
    rs1_addr = 5'd8;
    step();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3;
    alu_data = 32'h33;
    ld_valid = 1'b1; ld_rd = 5'd8;
    ld_rdata = 32'h88;
    step();
    alu_valid = 1'b0;
    chk("blk_hz", 32'(rs1_hazard), 1);
    wr_chk("blk_alu", 5'd3, 32'h33);
    step();
    ld_valid = 1'b0;
    chk("blk_clr", 32'(rs1_hazard), 0);
    wr_chk("blk_ld", 5'd8, 32'h88);

    // x0 handling
    alu_valid = 1'b1; alu_rd = 5'd0;
    alu_data = 32'h55;
    #1;
    chk("x0_alu_rdy", 32'(ld_ready), 1);
    step();
    chk("x0_alu_wen", 32'(w_enabled), 0);
    ld_valid = 1'b1; ld_rd = 5'd4;
    ld_rdata = 32'h44;
    step();
    alu_valid = 1'b0; ld_valid = 1'b0;
    wr_chk("x0_alu_ld", 5'd4, 32'h44);
    ld_valid = 1'b1; ld_rd = 5'd0;
    ld_rdata = 32'h99;
    #1;
    chk("x0_ld_rdy", 32'(ld_ready), 1);
    step();
    ld_valid = 1'b0;
    chk("x0_ld_wen", 32'(w_enabled), 0);
    chk("x0_ld_data", w_data, 32'h44);
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1_addr = 5'd0;
    step();
    issue_valid = 1'b0;
    chk("x0_hz", 32'(rs1_hazard), 0);

    // reset mid-operation
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    rs1_addr = 5'd9; rs2_addr = 5'd12;
    #1;
    chk("mr_set", 32'(rs1_hazard), 1);
    alu_valid = 1'b1; alu_rd = 5'd2;
    alu_data = 32'h22;
    ld_valid = 1'b1; ld_rd = 5'd9;
    ld_funct3 = 3'b100; ld_offset = 2'd2;
    ld_rdata = 32'h00AB0000;
    issue_valid = 1'b1; issue_rd = 5'd12;
    rst = 1'b1;
    step();
    rst = 1'b0;
    alu_valid = 1'b0; issue_valid = 1'b0;
    #1;
    chk("mr_hz1", 32'(rs1_hazard), 0);
    chk("mr_hz2", 32'(rs2_hazard), 0);
    chk("mr_wen", 32'(w_enabled), 0);
    chk("mr_cnt", wb_count, 0);
    step();
    ld_valid = 1'b0;
    wr_chk("mr_ld", 5'd9, 32'h000000AB);
    chk("mr_cnt1", wb_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
